// File: rtl/test_chain_sequencer.sv
// test_chain_sequencer: launches self-test stages strictly in order, guards each with a watchdog,
// and tallies pass/fail/timeout results along with the first failing stage.
module test_chain_sequencer #(
    parameter int N_STAGES = 16,
    parameter int TIMEOUT  = 1000000,
    parameter int TMR_W    = 20,
    localparam int IDXW = $clog2(N_STAGES),
    localparam int CNTW = IDXW + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    output logic [N_STAGES-1:0] stage_start,
    input  logic [N_STAGES-1:0] stage_finish,
    input  logic [N_STAGES-1:0] stage_fail,
    output logic                busy,
    output logic                done,
    output logic [IDXW-1:0]     cur_stage,
    output logic [CNTW-1:0]     pass_count,
    output logic [CNTW-1:0]     fail_count,
    output logic [CNTW-1:0]     timeout_count,
    output logic                first_fail_valid,
    output logic [IDXW-1:0]     first_fail_idx
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic entry, entry_n;
    logic [N_STAGES-1:0] start_n;
    logic [IDXW-1:0] cur_n, ffi_n;
    logic [CNTW-1:0] pass_n, fail_n, to_n;
    logic ffv_n, fin, adv, bad, last;

    assign busy = state == WAIT;
    assign done = state == DONE;
    assign fin  = stage_finish[cur_stage];
    assign last = cur_stage == IDXW'(N_STAGES - 1);

    always_comb begin
        state_n = state;
        cur_n   = cur_stage;
        start_n = stage_start;
        timer_n = timer;
        entry_n = 1'b0;
        pass_n  = pass_count;
        fail_n  = fail_count;
        to_n    = timeout_count;
        ffv_n   = first_fail_valid;
        ffi_n   = first_fail_idx;
        adv     = 1'b0;
        bad     = 1'b0;
        if (state != WAIT) begin
            if (go) begin
                state_n = WAIT;
                cur_n   = '0;
                start_n = N_STAGES'(1);
                timer_n = '0;
                entry_n = 1'b1;
                pass_n  = '0;
                fail_n  = '0;
                to_n    = '0;
                ffv_n   = 1'b0;
                ffi_n   = '0;
            end
        end else if (entry) begin
            timer_n = '0;
        end else if (fin) begin
            adv    = 1'b1;
            bad    = stage_fail[cur_stage];
            fail_n = bad ? fail_count + CNTW'(1) : fail_count;
            pass_n = bad ? pass_count : pass_count + CNTW'(1);
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            adv  = 1'b1;
            bad  = 1'b1;
            to_n = timeout_count + CNTW'(1);
        end else begin
            timer_n = timer + TMR_W'(1);
        end
        // only the first fail or timeout of a run is latched
        if (bad && !first_fail_valid) begin
            ffv_n = 1'b1;
            ffi_n = cur_stage;
        end
        if (adv) begin
            timer_n = '0;
            if (last) begin
                state_n = DONE;
            end else begin
                cur_n   = cur_stage + IDXW'(1);
                start_n = stage_start | (N_STAGES'(1) << cur_n);
                entry_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            cur_stage        <= '0;
            stage_start      <= '0;
            timer            <= '0;
            entry            <= 1'b0;
            pass_count       <= '0;
            fail_count       <= '0;
            timeout_count    <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else begin
            state            <= state_n;
            cur_stage        <= cur_n;
            stage_start      <= start_n;
            timer            <= timer_n;
            entry            <= entry_n;
            pass_count       <= pass_n;
            fail_count       <= fail_n;
            timeout_count    <= to_n;
            first_fail_valid <= ffv_n;
            first_fail_idx   <= ffi_n;
        end
    end
endmodule

// File: tb/tb_test_chain_sequencer.sv
// tb_test_chain_sequencer: directed scenarios for the test chain sequencer (4 stages, timeout 8).
module tb_test_chain_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [3:0] stage_start;
    logic [3:0] stage_finish = '0;
    logic [3:0] stage_fail = '0;
    logic       busy, done;
    logic [1:0] cur_stage;
    logic [2:0] pass_count, fail_count, timeout_count;
    logic       first_fail_valid;
    logic [1:0] first_fail_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t_start[4];
    logic [3:0] snap[4];
    logic [1:0] cur_snap[4];

    test_chain_sequencer #(.N_STAGES(4), .TIMEOUT(8), .TMR_W(4)) dut (
        .clk(clk), .reset(reset), .go(go),
        .stage_start(stage_start), .stage_finish(stage_finish), .stage_fail(stage_fail),
        .busy(busy), .done(done), .cur_stage(cur_stage),
        .pass_count(pass_count), .fail_count(fail_count), .timeout_count(timeout_count),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Delay d[i] = negedges after start bit i before finish[i] rises; -1 = never finishes.
    task automatic do_run(input int d0, input int d1, input int d2, input int d3, input logic [3:0] fm);
        int d[4];
        int n;
        d = '{d0, d1, d2, d3};
        stage_finish = '0;
        stage_fail = '0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!stage_start[i] && n < 50) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 50) begin
                failures++;
                $display("FAIL start_wait%0d: start bit never rose, got %b expected bit %0d set", i, stage_start, i);
                return;
            end
            t_start[i] = cyc;
            snap[i] = stage_start;
            cur_snap[i] = cur_stage;
            if (d[i] >= 0) begin
                repeat (d[i]) @(negedge clk);
                stage_finish[i] = 1'b1;
                stage_fail[i] = fm[i];
            end
        end
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            failures++;
            $display("FAIL done_wait: done=%b expected 1", done);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, first_fail_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, first_fail_valid});
        end
        checks++;
        if (stage_start !== 4'b0000) begin
            failures++;
            $display("FAIL reset_start: got %b expected 0000", stage_start);
        end
        checks++;
        if ({pass_count, fail_count, timeout_count} !== 9'd0) begin
            failures++;
            $display("FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", pass_count, fail_count, timeout_count);
        end
        checks++;
        if ({cur_stage, first_fail_idx} !== 4'd0) begin
            failures++;
            $display("FAIL reset_idx: got cur=%0d ffi=%0d expected 0/0", cur_stage, first_fail_idx);
        end
    endtask

    task automatic test_all_pass;
        logic [3:0] exp;
        do_run(3, 3, 3, 3, 4'b0000);
        exp = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp[i] = 1'b1;
            checks++;
            if (snap[i] !== exp || cur_snap[i] !== 2'(i)) begin
                failures++;
                $display("FAIL pass_start%0d: got %b cur=%0d expected %b cur=%0d", i, snap[i], cur_snap[i], exp, i);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (t_start[i+1] - t_start[i] != 4) begin
                failures++;
                $display("FAIL pass_latency%0d: got %0d cycles expected 4", i, t_start[i+1] - t_start[i]);
            end
        end
        checks++;
        if ({done, busy, first_fail_valid} !== 3'b100 || stage_start !== 4'b1111 || cur_stage !== 2'd3) begin
            failures++;
            $display("FAIL pass_done: got done=%b busy=%b ffv=%b start=%b cur=%0d expected 1 0 0 1111 3",
                     done, busy, first_fail_valid, stage_start, cur_stage);
        end
        checks++;
        if (pass_count !== 3'd4 || fail_count !== 3'd0 || timeout_count !== 3'd0) begin
            failures++;
            $display("FAIL pass_counts: got %0d/%0d/%0d expected 4/0/0", pass_count, fail_count, timeout_count);
        end
    endtask

    task automatic test_fail_stage2;
        do_run(3, 3, 3, 3, 4'b0100);
        checks++;
        if (pass_count !== 3'd3 || fail_count !== 3'd1 || timeout_count !== 3'd0) begin
            failures++;
            $display("FAIL fail2_counts: got %0d/%0d/%0d expected 3/1/0", pass_count, fail_count, timeout_count);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_idx !== 2'd2) begin
            failures++;
            $display("FAIL fail2_first: got v=%b idx=%0d expected 1/2", first_fail_valid, first_fail_idx);
        end
    endtask

    task automatic test_timeout;
        do_run(3, -1, 3, 3, 4'b0000);
        checks++;
        if (t_start[2] - t_start[1] != 9) begin
            failures++;
            $display("FAIL tmo_latency: got %0d cycles expected 9", t_start[2] - t_start[1]);
        end
        checks++;
        if (pass_count !== 3'd3 || fail_count !== 3'd0 || timeout_count !== 3'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL tmo_counts: got %0d/%0d/%0d done=%b expected 3/0/1 1",
                     pass_count, fail_count, timeout_count, done);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_idx !== 2'd1) begin
            failures++;
            $display("FAIL tmo_first: got v=%b idx=%0d expected 1/1", first_fail_valid, first_fail_idx);
        end
    endtask

    task automatic test_finish_at_timeout;
        do_run(3, 3, 3, 8, 4'b0000);
        checks++;
        if (pass_count !== 3'd4 || timeout_count !== 3'd0 || first_fail_valid !== 1'b0) begin
            failures++;
            $display("FAIL edge_counts: got pass=%0d tmo=%0d ffv=%b expected 4/0/0",
                     pass_count, timeout_count, first_fail_valid);
        end
    endtask

    task automatic test_fail_then_timeout;
        do_run(3, -1, 3, 3, 4'b0001);
        checks++;
        if (pass_count !== 3'd2 || fail_count !== 3'd1 || timeout_count !== 3'd1) begin
            failures++;
            $display("FAIL ft_counts: got %0d/%0d/%0d expected 2/1/1", pass_count, fail_count, timeout_count);
        end
        checks++;
        if (first_fail_valid !== 1'b1 || first_fail_idx !== 2'd0) begin
            failures++;
            $display("FAIL ft_first: got v=%b idx=%0d expected 1/0", first_fail_valid, first_fail_idx);
        end
    endtask

    task automatic test_reset_and_go;
        int n;
        stage_finish = '0;
        stage_fail = '0;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        stage_finish[0] = 1'b1;
        stage_fail[0] = 1'b1;
        repeat (2) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (cur_stage !== 2'd1 || stage_start !== 4'b0011 || busy !== 1'b1 || fail_count !== 3'd1) begin
            failures++;
            $display("FAIL busy_go: got cur=%0d start=%b busy=%b fail=%0d expected 1 0011 1 1",
                     cur_stage, stage_start, busy, fail_count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, done, first_fail_valid, stage_start, cur_stage, first_fail_idx,
             pass_count, fail_count, timeout_count} !== 20'd0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b ffv=%b start=%b cur=%0d counts=%0d/%0d/%0d expected all 0",
                     busy, done, first_fail_valid, stage_start, cur_stage, pass_count, fail_count, timeout_count);
        end
        stage_finish = 4'b1111;
        stage_fail = 4'b1010;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1 || pass_count !== 3'd2 || fail_count !== 3'd2 || first_fail_idx !== 2'd1) begin
            failures++;
            $display("FAIL fast_run: got done=%b pass=%0d fail=%0d ffi=%0d expected 1 2 2 1",
                     done, pass_count, fail_count, first_fail_idx);
        end
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        checks++;
        if ({pass_count, fail_count, timeout_count} !== 9'd0 || first_fail_valid !== 1'b0 ||
            stage_start !== 4'b0001 || cur_stage !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart: got counts=%0d/%0d/%0d ffv=%b start=%b cur=%0d busy=%b done=%b expected 0/0/0 0 0001 0 1 0",
                     pass_count, fail_count, timeout_count, first_fail_valid, stage_start, cur_stage, busy, done);
        end
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_fail_stage2();
        test_timeout();
        test_finish_at_timeout();
        test_fail_then_timeout();
        test_reset_and_go();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
